semaforo_temporizador: RTL

Phase timer for the traffic-light controller: watches the one-hot light outputs (red/ylw/grn) of the semaphore FSM and produces the `timeout` pulse that FSM consumes. It is the other end of the FSM's `timeout` input. On each light-phase change it loads a per-phase duration, counts down, and emits one single-cycle `timeout` when the phase has lasted its programmed time. It also flags illegal light combinations.

---
 rtl/semaforo_temporizador_pkg.sv | 22 ++
 rtl/semaforo_temporizador_contador_carga.sv | 38 +++
 rtl/semaforo_temporizador.sv | 120 ++++++++++++
 3 files changed

// File: rtl/semaforo_temporizador_pkg.sv
// Shared definitions for the traffic-light controller: FSM state encodings
// and one-hot light-vector constants, used by the semaphore FSM and its timer.
package semaforo_temporizador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_EXPIRED = 2'd2,
    ST_FAULT   = 2'd3
  } estado_t;

  // Light vector order is {red, ylw, grn}.
  localparam logic [2:0] LUZ_APAG = 3'b000;
  localparam logic [2:0] LUZ_VERM = 3'b100;
  localparam logic [2:0] LUZ_AMAR = 3'b010;
  localparam logic [2:0] LUZ_VERD = 3'b001;

  function automatic logic luz_legal(input logic [2:0] luz);
    return $onehot(luz);
  endfunction

endpackage

// File: rtl/semaforo_temporizador_contador_carga.sv
// WIDTH-bit loadable down-counter that stops at zero; load wins over enable.
module contador_carga #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/semaforo_temporizador.sv
// Phase timer for the traffic-light FSM: reloads a per-phase duration on every
// light change, pulses timeout once when the phase expires, flags illegal lights.
module semaforo_temporizador
  import semaforo_temporizador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int T_GRN = 20,
  parameter int T_YLW = 4,
  parameter int T_RED = 15
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             red,
  input  logic             ylw,
  input  logic             grn,
  output logic             timeout,
  output logic             expired,
  output logic             fault,
  output logic [WIDTH-1:0] remaining
);

  localparam int T_MAX = (1 << WIDTH) - 1;

  if (T_GRN < 1 || T_GRN > T_MAX || T_YLW < 1 || T_YLW > T_MAX ||
      T_RED < 1 || T_RED > T_MAX) begin : g_bad_duration
    $error("semaforo_temporizador: phase durations must be 1..2^WIDTH-1");
  end

  function automatic logic [WIDTH-1:0] duracao(input logic [2:0] luz);
    case (luz)
      LUZ_VERD: return WIDTH'(T_GRN - 1);
      LUZ_AMAR: return WIDTH'(T_YLW - 1);
      LUZ_VERM: return WIDTH'(T_RED - 1);
      default:  return '0;
    endcase
  endfunction

  estado_t          state_q, state_d;
  logic [2:0]       p_q, p_d;
  logic             timeout_q, timeout_d;
  logic             expired_q, expired_d;
  logic             fault_q, fault_d;

  logic [2:0]       luz;
  logic             legal;
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_zero;
  logic [WIDTH-1:0] cnt_count;

  assign luz   = {red, ylw, grn};
  assign legal = luz_legal(luz);

  contador_carga #(.WIDTH(WIDTH)) u_contador (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    timeout_d    = 1'b0;
    expired_d    = expired_q;
    fault_d      = fault_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;

    // A legal light leaving FAULT restarts the phase even when it matches P.
    if (legal && ((luz != p_q) || (state_q == ST_FAULT))) begin
      state_d      = ST_COUNT;
      p_d          = luz;
      cnt_load     = 1'b1;
      cnt_load_val = duracao(luz);
      expired_d    = 1'b0;
      fault_d      = 1'b0;
    end else if (!legal && !((state_q == ST_IDLE) && (luz == LUZ_APAG))) begin
      state_d   = ST_FAULT;
      cnt_load  = 1'b1;
      expired_d = 1'b0;
      fault_d   = 1'b1;
    end else if (state_q == ST_COUNT) begin
      if (cnt_zero) begin
        state_d   = ST_EXPIRED;
        timeout_d = 1'b1;
        expired_d = 1'b1;
      end else begin
        cnt_en = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      p_q       <= LUZ_APAG;
      timeout_q <= 1'b0;
      expired_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      timeout_q <= timeout_d;
      expired_q <= expired_d;
      fault_q   <= fault_d;
    end
  end

  assign timeout   = timeout_q;
  assign expired   = expired_q;
  assign fault     = fault_q;
  assign remaining = cnt_count;

endmodule
